// File: rtl/goruntu_yazici.sv
// goruntu_yazici: result-capture stage. Accepts the processed pixel stream
// over a valid/ready handshake and writes each pixel, in order, into the
// result RAM. Keeps a pixel count and a running checksum. Flags frames that
// are too short or too long, and reports frame completion with a sticky flag.
module goruntu_yazici #(
  parameter int PIKSEL = 76800,
  parameter int A      = 17,
  parameter int V      = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [V-1:0] veri_i,
  input  logic         veri_gecerli_i,
  input  logic         islem_bitti_i,
  output logic         veri_al_o,
  output logic         ram_en_o,
  output logic         ram_we_o,
  output logic [A-1:0] ram_addr_o,
  output logic [V-1:0] ram_data_o,
  output logic [A-1:0] sayac_o,
  output logic [24:0]  toplam_o,
  output logic         son_o,
  output logic         hata_o
);

  localparam int T = 25;
  localparam logic [A-1:0] SON_ADRES = A'(PIKSEL - 1);

  typedef enum logic [1:0] {
    BOSTA,
    ALIM,
    SON_BEKLE,
    BITTI
  } durum_t;

  durum_t       durum_q, durum_d;

  logic         ram_en_q,   ram_en_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic [V-1:0] ram_data_q, ram_data_d;
  logic [A-1:0] sayac_q,    sayac_d;
  logic [T-1:0] toplam_q,   toplam_d;
  logic         son_q,      son_d;
  logic         hata_q,     hata_d;

  logic         aktarim;
  logic         son_piksel;

  // A transfer needs both sides of the handshake. The frame completes when
  // the transfer carries the last pixel of the frame.
  assign aktarim    = veri_gecerli_i && veri_al_o;
  assign son_piksel = aktarim && (sayac_q == SON_ADRES);

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the
    // statements are written in.
    if (rst_i) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next-state logic. islem_bitti_i is still evaluated in ALIM while
  // en_i is low.
  always_comb begin
    // NOTE: every always_comb output gets a default first. Without it, any
    // path that leaves the output unassigned would infer a latch.
    durum_d = durum_q;
    unique case (durum_q)
      BOSTA:     if (en_i) durum_d = ALIM;
      ALIM: begin
        if (son_piksel) begin
          durum_d = islem_bitti_i ? BITTI : SON_BEKLE;
        end else if (islem_bitti_i) begin
          durum_d = BITTI;
        end
      end
      SON_BEKLE: if (islem_bitti_i) durum_d = BITTI;
      BITTI:     if (!en_i) durum_d = BOSTA;
      default:   durum_d = BOSTA;
    endcase
  end

  // Output decode. Ready is high only in ALIM while the block is enabled.
  always_comb begin
    veri_al_o = 1'b0;
    if (durum_q == ALIM) veri_al_o = en_i;
  end

  // Datapath next-state: write request, counters, and the sticky flags.
  always_comb begin
    ram_en_d   = aktarim;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    sayac_d    = sayac_q;
    toplam_d   = toplam_q;
    son_d      = son_q;
    hata_d     = hata_q;

    if (aktarim) begin
      ram_addr_d = sayac_q;
      ram_data_d = veri_i;
      sayac_d    = sayac_q + 1'b1;
      toplam_d   = toplam_q + T'(veri_i);
    end

    unique case (durum_q)
      BOSTA: begin
        if (en_i) begin
          sayac_d  = '0;
          toplam_d = '0;
          son_d    = 1'b0;
          hata_d   = 1'b0;
        end
      end
      ALIM: begin
        if (son_piksel) begin
          if (islem_bitti_i) son_d = 1'b1;
        end else if (islem_bitti_i) begin
          hata_d = 1'b1;
          son_d  = 1'b1;
        end
      end
      SON_BEKLE: begin
        if (islem_bitti_i) begin
          son_d = 1'b1;
        end else if (veri_gecerli_i) begin
          hata_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. A synchronous reset also cancels a write that the
  // same edge would otherwise have issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      sayac_q    <= '0;
      toplam_q   <= '0;
      son_q      <= 1'b0;
      hata_q     <= 1'b0;
    end else begin
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      sayac_q    <= sayac_d;
      toplam_q   <= toplam_d;
      son_q      <= son_d;
      hata_q     <= hata_d;
    end
  end

  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_en_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign sayac_o    = sayac_q;
  assign toplam_o   = toplam_q;
  assign son_o      = son_q;
  assign hata_o     = hata_q;

endmodule

// File: tb/tb_goruntu_yazici.sv
// Testbench for goruntu_yazici. A 16-pixel instance runs the directed and
// random frames against a frame-level reference model. Expected RAM writes
// go into a scoreboard queue, and a monitor drains that queue. A full-size
// instance runs one 76800-pixel frame alongside it.
module tb_goruntu_yazici;

  localparam int P  = 16;
  localparam int PB = 76800;
  localparam int A  = 17;
  localparam int V  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic         rst = 1'b1, en = 1'b0, vld = 1'b0, bitti = 1'b0;
  logic [V-1:0] d = '0;
  logic         s_al, s_ram_en, s_ram_we, s_son, s_hata;
  logic [A-1:0] s_addr, s_sayac;
  logic [V-1:0] s_data;
  logic [24:0]  s_toplam;

  goruntu_yazici #(.PIKSEL(P), .A(A), .V(V)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .veri_i(d),
    .veri_gecerli_i(vld), .islem_bitti_i(bitti),
    .veri_al_o(s_al), .ram_en_o(s_ram_en), .ram_we_o(s_ram_we),
    .ram_addr_o(s_addr), .ram_data_o(s_data), .sayac_o(s_sayac),
    .toplam_o(s_toplam), .son_o(s_son), .hata_o(s_hata)
  );

  // Full-size instance
  logic         b_rst = 1'b1, b_en = 1'b0, b_vld = 1'b0, b_bitti = 1'b0;
  logic [V-1:0] b_d = '0;
  logic         b_al, b_ram_en, b_ram_we, b_son, b_hata;
  logic [A-1:0] b_addr, b_sayac;
  logic [V-1:0] b_data;
  logic [24:0]  b_toplam;

  goruntu_yazici #(.PIKSEL(PB), .A(A), .V(V)) dut_big (
    .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .veri_i(b_d),
    .veri_gecerli_i(b_vld), .islem_bitti_i(b_bitti),
    .veri_al_o(b_al), .ram_en_o(b_ram_en), .ram_we_o(b_ram_we),
    .ram_addr_o(b_addr), .ram_data_o(b_data), .sayac_o(b_sayac),
    .toplam_o(b_toplam), .son_o(b_son), .hata_o(b_hata)
  );

  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame as seen from outside.
  typedef struct packed {
    logic [A-1:0] addr;
    logic [V-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef enum {M_IDLE, M_RECV, M_WAIT, M_DONE} mphase_t;
  mphase_t m_ph   = M_IDLE;
  int      m_cnt  = 0;
  longint  m_sum  = 0;
  bit      m_err  = 0;
  bit      m_done = 0;

  task automatic m_step(input bit r, input bit e, input bit v,
                        input logic [V-1:0] dd, input bit b);
    bit xfer;
    if (r) begin
      m_ph = M_IDLE; m_cnt = 0; m_sum = 0; m_err = 0; m_done = 0;
      return;
    end
    case (m_ph)
      M_IDLE: if (e) begin
        m_cnt = 0; m_sum = 0; m_err = 0; m_done = 0; m_ph = M_RECV;
      end
      M_RECV: begin
        xfer = v && e;
        if (xfer) begin
          exp_q.push_back(wr_t'{addr: A'(m_cnt), data: dd});
          m_cnt++;
          m_sum += longint'(dd);
        end
        if (xfer && m_cnt == P) begin
          if (b) begin m_ph = M_DONE; m_done = 1; end
          else m_ph = M_WAIT;
        end else if (b) begin
          m_err = 1; m_done = 1; m_ph = M_DONE;
        end
      end
      M_WAIT: begin
        if (b) begin m_ph = M_DONE; m_done = 1; end
        else if (v) m_err = 1;
      end
      M_DONE: if (!e) m_ph = M_IDLE;
      default: ;
    endcase
  endtask

  // Drive one cycle. Status outputs are checked mid-cycle, and then the model
  // advances over the coming edge.
  task automatic cyc(input bit r, input bit e, input bit v,
                     input logic [V-1:0] dd, input bit b);
    rst = r; en = e; vld = v; d = dd; bitti = b;
    @(negedge clk);
    check("veri_al", s_al, (m_ph == M_RECV) && e);
    check("sayac", s_sayac, m_cnt);
    check("toplam", s_toplam, m_sum);
    check("son", s_son, m_done);
    check("hata", s_hata, m_err);
    m_step(r, e, v, dd, b);
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cyc(0, 1, 0, 8'd0, 0);
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, V'($urandom), 0);
  endtask

  // Scoreboard monitor for the small instance.
  always @(negedge clk) begin
    wr_t w;
    if (s_ram_en) begin
      check("ram_we_eq_en", s_ram_we, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", s_addr, -1);
      end else begin
        w = exp_q.pop_front();
        check("ram_addr", s_addr, w.addr);
        check("ram_data", s_data, w.data);
      end
    end
  end

  // Monitor for the full-size instance.
  int          b_wcnt = 0;
  int          b_err  = 0;
  logic [A-1:0] b_last = '0;
  always @(negedge clk) begin
    if (b_ram_en) begin
      if (b_addr != A'(b_wcnt) || b_data != 8'd255 || !b_ram_we) b_err++;
      b_last = b_addr;
      b_wcnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      // Small-instance scenarios
      begin
        cyc(1, 0, 0, 8'd0, 0);
        cyc(1, 0, 0, 8'd0, 0);
        check("rst_ram_en", s_ram_en, 0);
        check("rst_ram_addr", s_addr, 0);
        check("rst_ram_data", s_data, 0);

        // Full frame, pixels 0..15, bitti two cycles after the last pixel
        start_frame();
        for (int i = 0; i < P; i++) cyc(0, 1, 1, V'(i), 0);
        cyc(0, 1, 0, 8'd0, 0);
        cyc(0, 1, 0, 8'd0, 0);
        cyc(0, 1, 0, 8'd0, 1);
        cyc(0, 1, 0, 8'd0, 0);
        check("full_toplam", s_toplam, 120);
        check("full_sayac", s_sayac, 16);
        check("full_son", s_son, 1);
        check("full_hata", s_hata, 0);
        cyc(0, 0, 0, 8'd0, 0);

        // Gapped valid with a 3-cycle enable drop
        start_frame();
        for (int g = 0; g < 300 && m_ph == M_RECV; g++)
          cyc(0, !(g >= 8 && g <= 10), 1'($urandom_range(0, 1)), V'($urandom), 0);
        check("gap_sayac", s_sayac, P);
        cyc(0, 1, 0, 8'd0, 1);
        cyc(0, 0, 0, 8'd0, 0);

        // Short frame: 10 pixels, then the core reports finished
        start_frame();
        send(10);
        cyc(0, 1, 0, 8'd0, 1);
        cyc(0, 1, 0, 8'd0, 0);
        check("short_hata", s_hata, 1);
        check("short_son", s_son, 1);
        check("short_sayac", s_sayac, 10);
        cyc(0, 0, 0, 8'd0, 0);

        // Overlong frame: valid keeps coming in SON_BEKLE
        start_frame();
        send(P);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, V'($urandom), 0);
        cyc(0, 1, 0, 8'd0, 1);
        cyc(0, 1, 0, 8'd0, 0);
        check("long_hata", s_hata, 1);
        check("long_sayac", s_sayac, P);
        cyc(0, 0, 0, 8'd0, 0);

        // Last pixel coincides with bitti
        start_frame();
        send(P - 1);
        cyc(0, 1, 1, V'($urandom), 1);
        cyc(0, 1, 0, 8'd0, 0);
        check("simul_son", s_son, 1);
        check("simul_hata", s_hata, 0);
        cyc(0, 0, 0, 8'd0, 0);

        // Second frame aborted by reset
        start_frame();
        send(5);
        cyc(1, 1, 1, V'($urandom), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, V'($urandom), 0);
        check("abort_ram_en", s_ram_en, 0);
        check("abort_addr", s_addr, 0);
        check("abort_data", s_data, 0);
        check("abort_sayac", s_sayac, 0);
        check("abort_son", s_son, 0);

        // Random frames with random enable, valid and finish timing
        for (int f = 0; f < 6; f++) begin
          start_frame();
          for (int c = 0; c < 40 && m_ph != M_DONE; c++)
            cyc(0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                V'($urandom), ($urandom_range(0, 24) == 0));
          for (int c = 0; c < 4 && m_ph != M_DONE; c++)
            cyc(0, 1, 0, 8'd0, 1);
          cyc(0, 0, 0, 8'd0, 0);
        end
        cyc(0, 0, 0, 8'd0, 0);
        check("scoreboard_empty", exp_q.size(), 0);
      end

      // Full-size frame of 255s
      begin
        longint b_sum;
        b_sum = 0;
        for (int i = 0; i < PB; i++) b_sum += 255;
        @(posedge clk); #1;
        b_rst = 0; b_en = 1; b_vld = 1; b_d = 8'd255;
        repeat (PB + 1) @(posedge clk);
        #1;
        b_vld = 0; b_bitti = 1;
        @(posedge clk); #1;
        b_bitti = 0;
        @(negedge clk);
        check("big_writes", b_wcnt, PB);
        check("big_write_errors", b_err, 0);
        check("big_last_addr", b_last, PB - 1);
        check("big_toplam", b_toplam, b_sum);
        check("big_sayac", b_sayac, PB);
        check("big_son", b_son, 1);
        check("big_hata", b_hata, 0);
        check("big_veri_al", b_al, 0);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
